// File: rtl/fp_round_pipe.sv
// fp_round_pipe: three-stage IEEE-style rounding pipeline with valid/ready flow control.
// Stage 1 decides the round increment, stage 2 adds it, stage 3 fixes up the
// exponent, saturates on overflow and raises {overflow, underflow, inexact}.
module fp_round_pipe #(
  parameter int unsigned EW = 8,
  parameter int unsigned FW = 23,
  parameter int unsigned TW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        rm,
  input  logic [EW+FW+4:0]  i,
  input  logic [TW-1:0]     tag_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+FW:0]    o,
  output logic [TW-1:0]     tag_o,
  output logic [2:0]        flags
);

  localparam int unsigned SW = FW + 1;  // significand with explicit leading bit
  localparam int unsigned RW = FW + 2;  // rounded significand incl. carry
  localparam int unsigned OW = EW + FW + 1;

  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RUP = 3'b010;
  localparam logic [2:0] RM_RDN = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Input field decode
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [SW-1:0] in_sig;
  logic          in_g, in_r, in_s;
  logic          in_spec;
  logic          in_inx;
  logic          in_inc;

  // Ready chain
  logic ld1, ld2, ld3;

  // Stage valid bits
  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;

  // Stage 1 registers
  logic          s1_sign_q;
  logic [EW-1:0] s1_exp_q;
  logic [SW-1:0] s1_sig_q;
  logic          s1_inc_q;
  logic          s1_inx_q;
  logic          s1_spec_q;
  logic [2:0]    s1_rm_q;
  logic [TW-1:0] s1_tag_q;

  // Stage 2 registers
  logic          s2_sign_q;
  logic [EW-1:0] s2_exp_q;
  logic [RW-1:0] s2_rnd_q;
  logic          s2_inx_q;
  logic          s2_spec_q;
  logic [2:0]    s2_rm_q;
  logic [TW-1:0] s2_tag_q;

  // Stage 3 next-state
  logic [EW-1:0] fx_exp;
  logic [FW-1:0] fx_frac;
  logic          fx_ovf;
  logic          fx_unf;
  logic          fx_to_inf;
  logic [OW-1:0] o_d;
  logic [2:0]    flags_d;

  // Split the packed input and choose the round increment for the mode
  always_comb begin
    in_sign = i[EW+FW+4];
    in_exp  = i[EW+FW+3 -: EW];
    in_sig  = i[FW+3 -: SW];
    in_g    = i[2];
    in_r    = i[1];
    in_s    = i[0];
    in_spec = &in_exp;
    in_inx  = (in_g | in_r | in_s) & ~in_spec;
    in_inc  = 1'b0;
    case (rm)
      RM_RTZ:  in_inc = 1'b0;
      RM_RUP:  in_inc = ~in_sign & (in_g | in_r | in_s);
      RM_RDN:  in_inc = in_sign & (in_g | in_r | in_s);
      RM_RMM:  in_inc = in_g;
      default: in_inc = in_g & (in_r | in_s | in_sig[0]);
    endcase
    // Inf/NaN bypass rounding entirely
    if (in_spec) begin
      in_inc = 1'b0;
    end
  end

  // Backward ready chain: a stage loads when empty or its successor loads
  always_comb begin
    ld3      = ~v3_q | out_ready;
    ld2      = ~v2_q | ld3;
    ld1      = ~v1_q | ld2;
    in_ready = ld1;
    v1_d     = ld1 ? in_valid : v1_q;
    v2_d     = ld2 ? v1_q     : v2_q;
    v3_d     = ld3 ? v2_q     : v3_q;
  end

  // Stage valid bits, cleared by reset so in-flight work is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
    end
  end

  assign out_valid = v3_q;

  // Stage 1 payload: increment decision
  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_sign_q <= in_sign;
      s1_exp_q  <= in_exp;
      s1_sig_q  <= in_sig;
      s1_inc_q  <= in_inc;
      s1_inx_q  <= in_inx;
      s1_spec_q <= in_spec;
      s1_rm_q   <= rm;
      s1_tag_q  <= tag_i;
    end
  end

  // Stage 2 payload: add increment with room for the carry
  always_ff @(posedge clk) begin
    if (ld2 && v1_q) begin
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s1_exp_q;
      s2_rnd_q  <= {1'b0, s1_sig_q} + RW'(s1_inc_q);
      s2_inx_q  <= s1_inx_q;
      s2_spec_q <= s1_spec_q;
      s2_rm_q   <= s1_rm_q;
      s2_tag_q  <= s1_tag_q;
    end
  end

  // Stage 3 combinational fix-up: renormalise, saturate, build flags
  always_comb begin
    fx_exp    = s2_exp_q;
    fx_frac   = s2_rnd_q[FW-1:0];
    fx_ovf    = 1'b0;
    fx_unf    = 1'b0;
    fx_to_inf = 1'b0;
    if (!s2_spec_q) begin
      if (s2_rnd_q[FW+1] && (s2_exp_q != '0)) begin
        fx_exp  = s2_exp_q + EW'(1);
        fx_frac = '0;
      end else if ((s2_exp_q == '0) && s2_rnd_q[FW]) begin
        fx_exp = EW'(1);
      end
      fx_ovf = &fx_exp;
      fx_unf = (fx_exp == '0) & s2_inx_q;
    end
    case (s2_rm_q)
      RM_RTZ:  fx_to_inf = 1'b0;
      RM_RUP:  fx_to_inf = ~s2_sign_q;
      RM_RDN:  fx_to_inf = s2_sign_q;
      default: fx_to_inf = 1'b1;
    endcase
    o_d = {s2_sign_q, fx_exp, fx_frac};
    if (fx_ovf) begin
      if (fx_to_inf) begin
        o_d = {s2_sign_q, {EW{1'b1}}, {FW{1'b0}}};
      end else begin
        o_d = {s2_sign_q, {(EW-1){1'b1}}, 1'b0, {FW{1'b1}}};
      end
    end
    flags_d = {fx_ovf, fx_unf, s2_inx_q | fx_ovf};
  end

  // Stage 3 output registers; held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o     <= '0;
      tag_o <= '0;
      flags <= '0;
    end else if (ld3 && v2_q) begin
      o     <= o_d;
      tag_o <= s2_tag_q;
      flags <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb_fp_round_pipe: randomized and directed checks of fp_round_pipe against a
// behavioural rounding model with an in-order scoreboard.
module tb_fp_round_pipe;

  localparam int unsigned EW = 8;
  localparam int unsigned FW = 23;
  localparam int unsigned TW = 4;
  localparam int unsigned IW = EW + FW + 5;
  localparam int unsigned OW = EW + FW + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    rm;
  logic [IW-1:0] i;
  logic [TW-1:0] tag_i;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] o;
  logic [TW-1:0] tag_o;
  logic [2:0]    flags;

  typedef struct {
    logic [OW-1:0] o;
    logic [TW-1:0] tag;
    logic [2:0]    fl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   acc_cnt = 0;
  int   out_cnt = 0;
  bit   stall_q = 1'b0;
  logic [OW+TW+2:0] prev_out;
  bit   rnd_done;

  fp_round_pipe #(.EW(EW), .FW(FW), .TW(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rm(rm), .i(i), .tag_i(tag_i), .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .tag_o(tag_o), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic sgn, input logic [7:0] e, input logic [23:0] sig,
                                       input logic g, input logic r, input logic s);
    return {sgn, e, sig, g, r, s};
  endfunction

  // Reference rounding computed with integer arithmetic from the mode rules
  function automatic void model(input logic [IW-1:0] d, input logic [2:0] m,
                                output logic [OW-1:0] mo, output logic [2:0] mf);
    bit sgn = d[IW-1];
    int e   = int'(d[IW-2 -: EW]);
    int sig = int'(d[FW+3 -: FW+1]);
    bit g = d[2];
    bit r = d[1];
    bit s = d[0];
    int mode = (m > 3'd4) ? 0 : int'(m);
    bit sticky = g | r | s;
    bit inc;
    bit to_inf;
    int rnd;
    int frac;
    if (e == 255) begin
      mo = {sgn, 8'(e), 23'(sig)};
      mf = 3'b000;
      return;
    end
    case (mode)
      0:       inc = g && (r || s || (sig % 2 == 1));
      1:       inc = 1'b0;
      2:       inc = !sgn && sticky;
      3:       inc = sgn && sticky;
      default: inc = g;
    endcase
    rnd  = sig + (inc ? 1 : 0);
    frac = rnd % (1 << FW);
    if (e != 0 && rnd >= (1 << (FW + 1))) begin
      e    = e + 1;
      frac = 0;
    end else if (e == 0 && rnd >= (1 << FW)) begin
      e = 1;
    end
    if (e == 255) begin
      to_inf = (mode == 0) || (mode == 4) || (mode == 2 && !sgn) || (mode == 3 && sgn);
      mo = to_inf ? {sgn, 8'hFF, 23'h0} : {sgn, 8'hFE, 23'h7FFFFF};
      mf = 3'b101;
    end else begin
      mo = {sgn, 8'(e), 23'(frac)};
      mf = {1'b0, (e == 0) && sticky, sticky};
    end
  endfunction

  function automatic logic [IW-1:0] rnd_in();
    logic [7:0]  e;
    logic [23:0] sig;
    int sel = $urandom_range(0, 7);
    case (sel)
      0:       e = 8'h00;
      1:       e = 8'hFE;
      2:       e = 8'hFF;
      3:       e = 8'h01;
      default: e = 8'($urandom_range(1, 254));
    endcase
    sig = 24'($urandom);
    if (e != 8'hFF) sig[23] = (e != 8'h00);
    if (e == 8'hFE && $urandom_range(0, 2) == 0) sig[22:0] = '1;
    if (e == 8'h00 && $urandom_range(0, 2) == 0) sig[22:0] = '1;
    return mk(1'($urandom), e, sig, 1'($urandom), 1'($urandom), 1'($urandom));
  endfunction

  // Monitor: record accepted inputs, compare delivered outputs, check stall hold
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (stall_q) begin
        check("hold_valid", 64'(out_valid), 64'(1));
        if (out_valid) check("hold_data", 64'({o, tag_o, flags}), 64'(prev_out));
      end
      stall_q  = out_valid && !out_ready;
      prev_out = {o, tag_o, flags};
      if (in_valid && in_ready) begin
        model(i, rm, mon_e.o, mon_e.fl);
        mon_e.tag = tag_i;
        sb.push_back(mon_e);
        acc_cnt++;
      end
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb.size() == 0) begin
          check("spurious_out", 64'(1), 64'(0));
        end else begin
          mon_e = sb.pop_front();
          check("o", 64'(o), 64'(mon_e.o));
          check("tag", 64'(tag_o), 64'(mon_e.tag));
          check("flags", 64'(flags), 64'(mon_e.fl));
        end
      end
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic send(input logic [IW-1:0] d, input logic [2:0] m, input logic [TW-1:0] t);
    bit done = 1'b0;
    in_valid = 1'b1;
    i        = d;
    rm       = m;
    tag_i    = t;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [IW-1:0] d, input logic [2:0] m,
                         input logic [OW-1:0] want_o, input logic [2:0] want_f);
    bit seen = 1'b0;
    out_ready = 1'b1;
    send(d, m, 4'hA);
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) begin
      check({name, "_timeout"}, 64'(0), 64'(1));
    end else begin
      check({name, "_o"}, 64'(o), 64'(want_o));
      check({name, "_flags"}, 64'(flags), 64'(want_f));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int n = 0; n < 200 && sb.size() > 0; n++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    check("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    i         = '0;
    rm        = '0;
    tag_i     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_o", 64'(o), 64'(0));
    check("rst_tag", 64'(tag_o), 64'(0));
    check("rst_flags", 64'(flags), 64'(0));
    @(posedge clk);
    #1;

    // Directed rounding cases
    run_one("rne_tie",   mk(0, 8'h7F, 24'h800000, 1, 0, 0), 3'b000, 32'h3F800000, 3'b001);
    run_one("rmm_tie",   mk(0, 8'h7F, 24'h800000, 1, 0, 0), 3'b100, 32'h3F800001, 3'b001);
    run_one("rm5_odd",   mk(0, 8'h7F, 24'h800001, 1, 0, 0), 3'b101, 32'h3F800002, 3'b001);
    run_one("ovf_rne",   mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0), 3'b000, 32'h7F800000, 3'b101);
    run_one("ovf_rtz",   mk(0, 8'hFE, 24'hFFFFFF, 1, 0, 0), 3'b001, 32'h7F7FFFFF, 3'b001);
    run_one("ovf_rdn",   mk(1, 8'hFE, 24'hFFFFFF, 1, 0, 0), 3'b011, 32'hFF800000, 3'b101);
    run_one("ovf_rup_p", mk(0, 8'hFE, 24'hFFFFFF, 0, 0, 1), 3'b010, 32'h7F800000, 3'b101);
    run_one("rup_neg",   mk(1, 8'hFE, 24'hFFFFFF, 1, 0, 0), 3'b010, 32'hFF7FFFFF, 3'b001);
    run_one("den_promo", mk(0, 8'h00, 24'h7FFFFF, 1, 1, 0), 3'b000, 32'h00800000, 3'b001);
    run_one("den_unf",   mk(0, 8'h00, 24'h000001, 0, 0, 1), 3'b001, 32'h00000001, 3'b011);
    run_one("nan_rdn",   mk(0, 8'hFF, 24'hC00000, 1, 0, 0), 3'b011, 32'h7FC00000, 3'b000);
    run_one("nan_rm6",   mk(0, 8'hFF, 24'hC00000, 1, 0, 0), 3'b110, 32'h7FC00000, 3'b000);
    run_one("neg_zero",  mk(1, 8'h00, 24'h000000, 0, 0, 0), 3'b000, 32'h80000000, 3'b000);

    // Backpressure: six tagged inputs against a stalled consumer
    out_ready = 1'b0;
    acc_cnt   = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) send(rnd_in(), 3'($urandom), 4'(k + 1));
      end
      begin
        repeat (5) @(posedge clk);
        #2;
        check("bp_accepted", 64'(acc_cnt), 64'(3));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("bp_no_gap", 64'(out_valid), 64'(1));
        end
      end
    join
    drain();

    // Reset with three transactions in flight
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) send(rnd_in(), 3'($urandom), 4'(k + 1));
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    out_cnt = 0;
    for (int k = 0; k < 4; k++) send(rnd_in(), 3'($urandom), 4'(k + 8));
    drain();
    check("post_rst_count", 64'(out_cnt), 64'(4));

    // Randomized traffic with random consumer stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rnd_in(), 3'($urandom), 4'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_round_pipe.md
FP_ROUND_PIPE -- requirements
Module: fp_round_pipe

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- EW, 8, exponent field width.
- FW, 23, stored fraction width.
- TW, 4, sideband tag width.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, reset; synchronous and active-low.
- in_valid, in, 1, input transaction present.
- in_ready, out, 1, block accepts the input this cycle.
- rm, in, 3, rounding mode; captured with its transaction.
- i, in, EW+FW+5, {sign, exp[EW], sig[FW+1] with explicit leading bit, g, r, s}.
- tag_i, in, TW, sideband tag; carried with the transaction.
- out_valid, out, 1, result present.
- out_ready, in, 1, downstream accepts the result.
- o, out, EW+FW+1, rounded result {sign, exp[EW], frac[FW]}.
- tag_o, out, TW, tag of the transaction on o.
- flags, out, 3, {overflow, underflow, inexact}.

Function
REQ-003 The pipeline SHALL have 3 stages, each with a valid bit: decide round increment; add and detect carry; fix up exponent, saturate and raise flags.
REQ-004 A transfer SHALL occur only when valid and ready are both high; latency from input transfer to out_valid SHALL be 3 cycles when there is no stall.
REQ-005 Stage k SHALL load when it is empty or stage k+1 loads; stage 3 loads when it is empty or out_ready=1; in_ready = stage-1 load condition (a combinational ready chain is permitted).
REQ-006 Full throughput SHALL be 1 transaction/cycle; when out_ready=0, up to 3 transactions SHALL be held with none lost, duplicated or reordered; o, tag_o and flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-007 The increment SHALL be as follows, where lsb = sig[0]:
- rm=000 (RNE): g&(r|s | lsb).
- rm=001 (RTZ): 0.
- rm=010 (RUP): ~sign&(g|r|s).
- rm=011 (RDN): sign&(g|r|s).
- rm=100 (RMM): g.
- rm=101..111: treated as RNE.
REQ-008 An input with exp all-ones (Inf/NaN) SHALL pass through unrounded: o = {sign, exp, sig[FW-1:0]}, flags = 000.
REQ-009 Rounding SHALL compute sig+inc in FW+2 bits.
- Carry out with exp≠0: exp+1 and frac=0.
- exp=0 with the rounded leading bit set: exp=1 (denormal promoted to normal).
- Otherwise exp is unchanged and frac = rounded[FW-1:0].
REQ-010 inexact SHALL be g|r|s for finite inputs.
REQ-011 overflow SHALL be 1 when the rounded exponent reaches all-ones from a finite input; the result then depends on mode:
- RNE/RMM: ±Inf.
- RTZ: ±max-finite.
- RUP: +Inf if positive, else -max-finite.
- RDN: -Inf if negative, else +max-finite.
- inexact is forced to 1.
REQ-012 underflow SHALL be 1 when the result exp=0 after rounding and inexact=1 (after-rounding tininess).
REQ-013 The sign SHALL pass unchanged, including for zero results.
REQ-014 Input with exp≠0 and sig leading bit 0 is outside contract; the output SHALL still be produced and the handshake SHALL remain correct.

Reset
REQ-015 While rst_n=0 at a clock edge, all stage valid bits SHALL clear, so out_valid=0 and in_ready=1 on the following cycle.
REQ-016 After reset, o, tag_o and flags SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight transactions; no stale result SHALL appear after reset is released.
REQ-018 Datapath registers other than those in REQ-016 need not be reset.

Verification (EW=8, FW=23)
REQ-019 RNE tie, even: exp=7F, sig=800000, g=1, r=0, s=0 -> o=3F800000, flags=001; the same input with RMM -> o=3F800001, flags=001.
REQ-020 Overflow: sign=0, exp=FE, sig=FFFFFF, g=1 -> RNE gives o=7F800000, flags=101; RTZ gives o=7F7FFFFF, flags=001; RDN with sign=1 gives o=FF800000, flags=101.
REQ-021 Denormal promotion: exp=00, sig=7FFFFF, g=r=1, RNE -> o=00800000, flags=001; exp=00, sig=000001, s=1, RTZ -> o=00000001, flags=011.
REQ-022 NaN passthrough: exp=FF, sig=C00000, g=1, any rm -> o=7FC00000, flags=000.
REQ-023 Backpressure: 6 back-to-back inputs with distinct tags, out_ready=0 for cycles 0-7 -> in_ready falls after 3 are accepted; after out_ready rises, all 6 results emerge in tag order with no gaps while in_valid and out_ready stay high.
REQ-024 Reset mid-stream: rst_n=0 for 1 cycle with 3 in flight -> out_valid=0 the next cycle, and the only results that follow are from transactions issued after reset.
